// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared edge/center-aligned period counter, double-buffered
// per-channel duties applied at the period boundary. Optional dead-time: `define DEADTIME_EN.
module pwm_multi_gen #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned BLANK  = 255
`ifdef DEADTIME_EN
    ,
    parameter int unsigned DT     = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    duty_vld,
    input  logic                    center_mode,
    output logic [NUM_CH-1:0]       pwm,
    output logic [NUM_CH-1:0]       pwm_n,
    output logic                    pwm_synch,
    output logic                    ovr_i_blank_n,
    output logic                    upd_pend
);

    localparam int unsigned      DW      = NUM_CH * WIDTH;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] BLANK_W = WIDTH'(BLANK);

    localparam logic [0:0] DIR_UP      = 1'b0;
    localparam logic [0:0] DIR_DN      = 1'b1;
    localparam logic [0:0] MODE_EDGE   = 1'b0;
    localparam logic [0:0] MODE_CENTER = 1'b1;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [0:0]        dir_q, dir_d;
    logic [0:0]        mode_q, mode_d;
    logic [0:0]        pmode_q, pmode_d;
    logic [DW-1:0]     duty_pend_q, duty_pend_d;
    logic [DW-1:0]     duty_act_q, duty_act_d;
    logic              upd_pend_q, upd_pend_d;
    logic              boundary_c;
    logic              load_c;
    logic [NUM_CH-1:0] raw_d;
    logic [NUM_CH-1:0] pwm_q, pwm_n_q;

    // Period counter: boundary_c marks the last cycle of the period (cnt becomes 0 next)
    always_comb begin
        boundary_c = 1'b0;
        cnt_d      = cnt_q + CNT_ONE;
        dir_d      = dir_q;
        if (mode_q == MODE_EDGE) begin
            dir_d      = DIR_UP;
            boundary_c = (cnt_q == CNT_MAX);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q - CNT_ONE;
                dir_d = DIR_DN;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                boundary_c = 1'b1;
                dir_d      = DIR_UP;
            end
        end
        if (load_c) begin
            dir_d = DIR_UP;
        end
    end

    assign load_c = boundary_c & (upd_pend_q | duty_vld);

    // Double buffer: a strobe on the boundary edge bypasses the pending stage
    always_comb begin
        duty_pend_d = duty_pend_q;
        pmode_d     = pmode_q;
        duty_act_d  = duty_act_q;
        mode_d      = mode_q;
        upd_pend_d  = upd_pend_q;
        if (duty_vld) begin
            duty_pend_d = duty;
            pmode_d     = center_mode;
        end
        if (load_c) begin
            duty_act_d = duty_vld ? duty : duty_pend_q;
            mode_d     = duty_vld ? center_mode : pmode_q;
            upd_pend_d = 1'b0;
        end else if (duty_vld) begin
            upd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            mode_q      <= MODE_EDGE;
            pmode_q     <= MODE_EDGE;
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            upd_pend_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            pmode_q     <= pmode_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            upd_pend_q  <= upd_pend_d;
        end
    end

    always_comb begin
        raw_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw_d[i] = (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
        end
    end

`ifdef DEADTIME_EN
    localparam int unsigned    DTW     = (DT < 1) ? 1 : $clog2(DT + 1);
    localparam logic [DTW-1:0] DT_LOAD = DTW'(DT);

    logic [NUM_CH-1:0]           raw_q;
    logic [NUM_CH-1:0][DTW-1:0]  dt_q, dt_d;
    logic [NUM_CH-1:0]           pwm_d, pwm_n_d;

    // Dead-time counter reloads on every raw transition; outputs gated until it expires
    always_comb begin
        dt_d    = dt_q;
        pwm_d   = '0;
        pwm_n_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (raw_d[i] != raw_q[i]) begin
                dt_d[i] = DT_LOAD;
            end else if (dt_q[i] != '0) begin
                dt_d[i] = dt_q[i] - DTW'(1);
            end
            pwm_d[i]   =  raw_d[i] & (dt_d[i] == '0);
            pwm_n_d[i] = ~raw_d[i] & (dt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q   <= '0;
            dt_q    <= {NUM_CH{DT_LOAD}};
            pwm_q   <= '0;
            pwm_n_q <= '0;
        end else begin
            raw_q   <= raw_d;
            dt_q    <= dt_d;
            pwm_q   <= pwm_d;
            pwm_n_q <= pwm_n_d;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q   <= '0;
            pwm_n_q <= '1;
        end else begin
            pwm_q   <= raw_d;
            pwm_n_q <= ~raw_d;
        end
    end
`endif

    assign pwm           = pwm_q;
    assign pwm_n         = pwm_n_q;
    assign pwm_synch     = boundary_c;
    assign ovr_i_blank_n = (cnt_q > BLANK_W);
    assign upd_pend      = upd_pend_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: per-period scoreboard of high-cycle counts plus directed
// checks of upd_pend, period length, blanking and asynchronous reset.
module tb_pwm_multi_gen;

    localparam int unsigned WIDTH  = 11;
    localparam int unsigned NUM_CH = 2;
`ifdef DEADTIME_EN
    localparam int PN_RST = 0;
`else
    localparam int PN_RST = 3;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*WIDTH-1:0] duty = '0;
    logic                    duty_vld = 1'b0;
    logic                    center_mode = 1'b0;
    logic [NUM_CH-1:0]       pwm;
    logic [NUM_CH-1:0]       pwm_n;
    logic                    pwm_synch;
    logic                    ovr_i_blank_n;
    logic                    upd_pend;

    pwm_multi_gen #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .BLANK  (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .duty          (duty),
        .duty_vld      (duty_vld),
        .center_mode   (center_mode),
        .pwm           (pwm),
        .pwm_n         (pwm_n),
        .pwm_synch     (pwm_synch),
        .ovr_i_blank_n (ovr_i_blank_n),
        .upd_pend      (upd_pend)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        int hi0;
        int hi1;
        int hin0;
        int lo0;
        int blank;
        int len;
        int runs0;
        int lead0;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;

    task automatic push(input int hi0, hi1, hin0, lo0, blank, len, runs0, lead0);
        exp_t e;
        e.hi0 = hi0; e.hi1 = hi1; e.hin0 = hin0; e.lo0 = lo0;
        e.blank = blank; e.len = len; e.runs0 = runs0; e.lead0 = lead0;
        exp_q.push_back(e);
    endtask

    // Monitor: a window spans the outputs produced by one period's compares
    // (from cnt==1 through the next cnt==0, i.e. one cycle after pwm_synch).
    bit mon_en = 1'b1;
    bit armed, synch_prev, prev0, low_seen;
    int a_hi0, a_hi1, a_hin0, a_lo0, a_blank, a_len, a_runs0, a_lead0, a_both;
    int widx = 0;

    task automatic clr_acc();
        a_hi0 = 0; a_hi1 = 0; a_hin0 = 0; a_lo0 = 0; a_blank = 0;
        a_len = 0; a_runs0 = 0; a_lead0 = 0; a_both = 0; low_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            armed      = 1'b0;
            synch_prev = 1'b0;
            prev0      = 1'b0;
            clr_acc();
        end else begin
            a_len++;
            a_hi0   += int'(pwm[0]);
            a_hi1   += int'(pwm[1]);
            a_hin0  += int'(pwm_n[0]);
            a_blank += int'(ovr_i_blank_n);
            if (!pwm[0] && !pwm_n[0]) a_lo0++;
            if ((pwm & pwm_n) != '0) a_both++;
            if (pwm[0] && !prev0) a_runs0++;
            if (!pwm[0]) low_seen = 1'b1;
            else if (!low_seen) a_lead0++;
            prev0 = pwm[0];
            if (synch_prev) begin
                if (armed) begin
                    widx++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL win%0d_unexpected: actual=period required=none", widx);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk($sformatf("win%0d_len", widx), a_len, m_e.len);
                        chk($sformatf("win%0d_hi0", widx), a_hi0, m_e.hi0);
                        chk($sformatf("win%0d_hi1", widx), a_hi1, m_e.hi1);
                        chk($sformatf("win%0d_hin0", widx), a_hin0, m_e.hin0);
                        chk($sformatf("win%0d_lo0", widx), a_lo0, m_e.lo0);
                        chk($sformatf("win%0d_blank", widx), a_blank, m_e.blank);
                        chk($sformatf("win%0d_lead0", widx), a_lead0, m_e.lead0);
                        chk($sformatf("win%0d_both_high", widx), a_both, 0);
                        if (m_e.runs0 >= 0)
                            chk($sformatf("win%0d_runs0", widx), a_runs0, m_e.runs0);
                    end
                end
                armed = 1'b1;
                clr_acc();
            end
            synch_prev = pwm_synch;
        end
    end

    task automatic wait_synch(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pwm_synch && n < 6000);
        if (!pwm_synch) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_synch: actual=timeout after %0d cycles required=pwm_synch", n);
        end
    endtask

    task automatic pulse(input int d0, input int d1, input bit cm);
        duty        = {WIDTH'(d1), WIDTH'(d0)};
        center_mode = cm;
        duty_vld    = 1'b1;
        @(negedge clk);
        duty_vld    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_pwm_n", int'(pwm_n), PN_RST);
        chk("rst_synch", int'(pwm_synch), 0);
        chk("rst_blank", int'(ovr_i_blank_n), 0);
        chk("rst_upd_pend", int'(upd_pend), 0);

        rst_n = 1'b1;
`ifdef DEADTIME_EN
        pulse(1024, 0, 1'b0);
        push(1020, 0, 1020, 8, 1792, 2048, 1, 0);
        push(1020, 0, 1020, 8, 1792, 2048, 1, 0);
        chk("dt_upd_pend_set", int'(upd_pend), 1);
        wait_synch(n);
        wait_synch(n);
        wait_synch(n);
        pulse(3, 0, 1'b0);
        push(0, 0, 2041, 7, 1792, 2048, 0, 0);
        push(0, 0, 2041, 7, 1792, 2048, 0, 0);
        chk("dt_bypass_no_pend", int'(upd_pend), 0);
        wait_synch(n);
        wait_synch(n);
`else
        // ch0=1024, ch1=0, edge mode
        pulse(1024, 0, 1'b0);
        push(1024, 0, 1024, 0, 1792, 2048, 1, 1024);
        push(1024, 0, 1024, 0, 1792, 2048, 1, 1024);
        chk("upd_pend_set", int'(upd_pend), 1);
        wait_synch(n);
        @(negedge clk);
        chk("upd_pend_cleared", int'(upd_pend), 0);
        wait_synch(n);
        chk("edge_period_first", n, 2047);
        wait_synch(n);
        chk("edge_period", n, 2048);

        // Bypass on the boundary edge, then a mid-period update
        pulse(300, 2047, 1'b0);
        push(300, 2047, 1748, 0, 1792, 2048, 1, 300);
        chk("bypass_no_pend", int'(upd_pend), 0);
        repeat (1000) @(negedge clk);
        pulse(600, 1, 1'b0);
        push(600, 1, 1448, 0, 1792, 2048, 1, 600);
        chk("mid_upd_pend", int'(upd_pend), 1);
        wait_synch(n);
        @(negedge clk);
        chk("mid_upd_applied", int'(upd_pend), 0);

        // Last write wins, then bypass overrides a pending value
        repeat (500) @(negedge clk);
        pulse(500, 5, 1'b0);
        repeat (500) @(negedge clk);
        pulse(700, 7, 1'b0);
        push(700, 7, 1348, 0, 1792, 2048, 1, 700);
        chk("lww_upd_pend", int'(upd_pend), 1);
        wait_synch(n);
        repeat (800) @(negedge clk);
        pulse(800, 8, 1'b0);
        wait_synch(n);
        pulse(900, 9, 1'b0);
        push(900, 9, 1148, 0, 1792, 2048, 1, 900);
        chk("bypass_over_pend", int'(upd_pend), 0);

        // Center mode ch0=100, ch1=MAX
        repeat (1000) @(negedge clk);
        pulse(100, 2047, 1'b1);
        push(199, 4093, 3895, 0, 3583, 4094, -1, 100);
        push(199, 4093, 3895, 0, 3583, 4094, -1, 100);
        wait_synch(n);
        wait_synch(n);
        chk("center_period", n, 4094);
        chk("center_synch_blank", int'(ovr_i_blank_n), 0);

        // Back to edge mode, applied only at the center boundary
        repeat (2000) @(negedge clk);
        pulse(2047, 0, 1'b0);
        push(2047, 0, 1, 0, 1792, 2048, -1, 2047);
        chk("mode_upd_pend", int'(upd_pend), 1);
        wait_synch(n);
        @(negedge clk);
        chk("blank_cnt0", int'(ovr_i_blank_n), 0);
        chk("mode_upd_applied", int'(upd_pend), 0);
        repeat (255) @(negedge clk);
        chk("blank_cnt255", int'(ovr_i_blank_n), 0);
        @(negedge clk);
        chk("blank_cnt256", int'(ovr_i_blank_n), 1);
        wait_synch(n);
        chk("synch_at_max", n, 1791);
        chk("blank_cnt_max", int'(ovr_i_blank_n), 1);
        chk("pwm_high_before_rst", int'(pwm[0]), 1);
`endif

        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a period with an update pending
        pulse(123, 0, 1'b0);
        chk("pre_rst_upd_pend", int'(upd_pend), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_pwm_n", int'(pwm_n), PN_RST);
        chk("async_rst_synch", int'(pwm_synch), 0);
        chk("async_rst_blank", int'(ovr_i_blank_n), 0);
        chk("async_rst_upd_pend", int'(upd_pend), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_synch(n);
        chk("post_rst_period", n, 2047);
        chk("post_rst_pwm", int'(pwm), 0);
        chk("post_rst_pwm_n", int'(pwm_n), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator for the motor-drive path. It has one shared period counter with edge-aligned or center-aligned counting. Each channel has a double-buffered duty register that takes new values only at the period boundary, so updates are glitch-free. It also provides period synch and over-current blanking outputs for the current-sense logic.

Parameters:
WIDTH, 11, counter/duty width in bits; MAX = 2^WIDTH-1
NUM_CH, 2, number of PWM channels
BLANK, 255, blanking threshold; ovr_i_blank_n is high only when cnt > BLANK
DT, 4, dead-time in clk cycles (used only with DEADTIME_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
duty  in  NUM_CH*WIDTH  requested duties; channel i is at [i*WIDTH +: WIDTH]
duty_vld  in  1  one-cycle strobe; captures duty and center_mode into the pending registers
center_mode  in  1  0 = edge-aligned, 1 = center-aligned (applied at the boundary)
pwm  out  NUM_CH  PWM outputs (high side)
pwm_n  out  NUM_CH  complementary outputs
pwm_synch  out  1  one-cycle pulse in the last cycle of each period
ovr_i_blank_n  out  1  low while current sense must be ignored
upd_pend  out  1  pending duty/mode not yet applied

Behaviour:
- Reset values:
  - cnt=0, dir=up, mode_act=edge.
  - pending and active duties all 0, pending mode=edge.
  - pwm=0, pwm_n=0 with DEADTIME_EN, pwm_n=1 without (~pwm).
  - upd_pend=0.
- Reset mid-operation takes effect immediately (asynchronous) on all state.
- Edge mode:
  - cnt counts 0..MAX, then wraps to 0.
  - Period is 2^WIDTH cycles.
- Center mode:
  - cnt counts up 0..MAX, then down MAX-1..1, then back to 0.
  - dir flips to down when cnt==MAX and to up when cnt==1 while counting down.
  - Period is 2*MAX cycles.
- Boundary = the clock edge on which cnt becomes 0. At that edge, if upd_pend or duty_vld:
  - active duties and mode_act load from pending.
  - dir is forced to up.
  - The compare during the cnt==0 cycle uses the new values.
- duty_vld:
  - Writes pending duties/mode and sets upd_pend.
  - A later duty_vld before the boundary overwrites pending (last write wins).
  - duty_vld on the boundary edge bypasses: the new value goes straight to active and upd_pend stays 0.
- Compare: raw[i] is registered, raw[i] <= (cnt < duty_act[i]). Latency is 1 cycle from cnt to output.
  - duty=0 gives constant low.
  - Edge mode, duty=MAX gives MAX high cycles per period; generally duty high cycles per period.
  - Center mode gives 2*duty-1 high cycles (duty >= 1), centred on cnt=0.
- pwm_synch (combinational from cnt/dir/mode_act):
  - Edge mode: 1 when cnt==MAX.
  - Center mode: 1 when cnt==1 and dir=down.
  - WIDTH=1 center mode is not supported.
- ovr_i_blank_n = (cnt > BLANK), combinational; same rule in both modes.
- Mode switch takes effect only at the boundary. There is never a partial period in the new mode.

Optional Feature:
DEADTIME_EN
- Defined:
  - Per channel there is a DT-cycle dead-time counter that restarts on each raw edge.
  - pwm[i] = raw & (counter expired); pwm_n[i] = ~raw & (counter expired).
  - Both outputs are low for DT cycles after every raw transition.
  - Raw pulses shorter than DT are suppressed entirely.
  - pwm and pwm_n are never both high.
- Undefined: pwm = raw, pwm_n = ~raw, no dead-time logic.

Test Plan:
1. Reset, then duty_vld with ch0=1024, ch1=0, edge mode -> after the first boundary, ch0 high 1024 of every 2048 cycles, ch1 constantly low, pwm_synch pulses every 2048 cycles at cnt=2047.
2. Edge mode, ch0=300 active, write 600 mid-period -> upd_pend=1 until the wrap; the current period keeps 300 high cycles, the next has 600, and no glitch appears.
3. Center mode, ch0=100 -> 199 high cycles in a 4094-cycle period, symmetric about cnt=0; pwm_synch at cnt=1 down.
4. Two duty_vld before the boundary (500, then 700), plus duty_vld exactly on the boundary edge -> only 700 and the bypass value apply at their boundaries; upd_pend is 0 after the bypass.
5. ovr_i_blank_n: edge mode -> low for cnt 0..255, high for cnt 256..2047; assert rst_n low mid-period -> all outputs return to reset values immediately.
6. DEADTIME_EN, DT=4, duty=1024 -> pwm and pwm_n never both high, 4-cycle low gap at each edge; duty=3 -> pwm stays low.
